// File: rtl/tcam_pkg.sv
// Shared definitions for the unencoded TCAM: write-engine state encoding,
// ceiling log2 for sizing, and the per-bit ternary compare.
package tcam_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_WRITING = 1'b1
  } wr_state_e;

  // Smallest r with 2**r >= n; returns 0 for n <= 1.
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < n) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  // A bit matches if either side marks it don't-care or the values agree.
  function automatic logic tern_bit(input logic s_data, input logic s_mask,
                                    input logic k_data, input logic k_mask);
    return s_mask | k_mask | ~(s_data ^ k_data);
  endfunction

endpackage

// File: rtl/tcam_entry.sv
// One TCAM entry: stored data, don't-care mask, valid flag and the
// combinational ternary compare against the lookup key.
module tcam_entry
  import tcam_pkg::*;
#(
  parameter int CMP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 commit,
  input  logic [CMP_WIDTH-1:0] wr_data,
  input  logic [CMP_WIDTH-1:0] wr_mask,
  input  logic [CMP_WIDTH-1:0] cmp_din,
  input  logic [CMP_WIDTH-1:0] cmp_data_mask,
  output logic                 hit
);

  logic [CMP_WIDTH-1:0] data_q, data_d;
  logic [CMP_WIDTH-1:0] mask_q, mask_d;
  logic                 valid_q, valid_d;
  logic                 all_bits;

  // Entry update: invalidate when a write targets it, load and validate on commit.
  always_comb begin
    data_d  = data_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    if (commit) begin
      data_d  = wr_data;
      mask_d  = wr_mask;
      valid_d = 1'b1;
    end else if (clr) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid flag, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Stored contents are don't-care until the entry is validated.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    mask_q <= mask_d;
  end

  // Ternary compare of every bit against the lookup key.
  always_comb begin
    all_bits = 1'b1;
    for (int b = 0; b < CMP_WIDTH; b++) begin
      all_bits = all_bits & tern_bit(data_q[b], mask_q[b], cmp_din[b], cmp_data_mask[b]);
    end
    hit = valid_q & all_bits;
  end

endmodule

// File: rtl/unencoded_tcam.sv
// Ternary CAM with registered, unencoded multi-match output and a
// multi-cycle write engine that holds busy for WR_LATENCY cycles per write.
module unencoded_tcam
  import tcam_pkg::*;
#(
  parameter int CMP_WIDTH  = 32,
  parameter int DEPTH      = 16,
  parameter int DEPTH_BITS = log2(DEPTH),
  parameter int WR_LATENCY = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] wr_addr,
  input  logic [CMP_WIDTH-1:0]  din,
  input  logic [CMP_WIDTH-1:0]  data_mask,
  input  logic [CMP_WIDTH-1:0]  cmp_din,
  input  logic [CMP_WIDTH-1:0]  cmp_data_mask,
  output logic                  busy,
  output logic                  match,
  output logic [DEPTH-1:0]      match_addr
);

  localparam int CNT_W = (log2(WR_LATENCY) > 0) ? log2(WR_LATENCY) : 1;

  wr_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_BITS-1:0] hold_addr_q, hold_addr_d;
  logic [CMP_WIDTH-1:0]  hold_data_q, hold_data_d;
  logic [CMP_WIDTH-1:0]  hold_mask_q, hold_mask_d;
  logic                  busy_q, busy_d;
  logic                  match_q, match_d;
  logic [DEPTH-1:0]      match_addr_q, match_addr_d;

  logic                  clr_en, commit_en, fwd_hit;
  logic [DEPTH-1:0]      clr_vec, commit_vec, hit_vec;

  // Write engine: latch the request, count down, commit at zero.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    hold_mask_d = hold_mask_q;
    clr_en      = 1'b0;
    commit_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (we) begin
          state_d     = ST_WRITING;
          cnt_d       = CNT_W'(WR_LATENCY - 1);
          hold_addr_d = wr_addr;
          hold_data_d = din;
          hold_mask_d = data_mask;
          clr_en      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITING: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          commit_en = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_WRITING);
  end

  // Per-entry strobes; an out-of-range address selects no entry.
  always_comb begin
    clr_vec    = {DEPTH{1'b0}};
    commit_vec = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      clr_vec[i]    = clr_en & (wr_addr == DEPTH_BITS'(i));
      commit_vec[i] = commit_en & (hold_addr_q == DEPTH_BITS'(i));
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    tcam_entry #(
      .CMP_WIDTH(CMP_WIDTH)
    ) u_entry (
      .clk          (clk),
      .reset        (reset),
      .clr          (clr_vec[gi]),
      .commit       (commit_vec[gi]),
      .wr_data      (hold_data_q),
      .wr_mask      (hold_mask_q),
      .cmp_din      (cmp_din),
      .cmp_data_mask(cmp_data_mask),
      .hit          (hit_vec[gi])
    );
  end

  // A key presented in the commit cycle already sees the new contents.
  always_comb begin
    fwd_hit = commit_en;
    for (int b = 0; b < CMP_WIDTH; b++) begin
      fwd_hit = fwd_hit & tern_bit(hold_data_q[b], hold_mask_q[b], cmp_din[b], cmp_data_mask[b]);
    end
    match_addr_d = hit_vec | (commit_vec & {DEPTH{fwd_hit}});
    match_d      = |match_addr_d;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      busy_q       <= 1'b0;
      match_q      <= 1'b0;
      match_addr_q <= {DEPTH{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      match_q      <= match_d;
      match_addr_q <= match_addr_d;
    end
  end

  // Holding registers carry no reset; they are only read while WRITING.
  always_ff @(posedge clk) begin
    hold_addr_q <= hold_addr_d;
    hold_data_q <= hold_data_d;
    hold_mask_q <= hold_mask_d;
  end

  assign busy       = busy_q;
  assign match      = match_q;
  assign match_addr = match_addr_q;

endmodule

// File: tb/tb_unencoded_tcam.sv
// Directed self-checking bench for unencoded_tcam (DEPTH=16, WR_LATENCY=16).
module tb_unencoded_tcam;

  localparam int CW  = 32;
  localparam int DP  = 16;
  localparam int AB  = 4;
  localparam int LAT = 16;

  logic          clk;
  logic          reset;
  logic          we;
  logic [AB-1:0] wr_addr;
  logic [CW-1:0] din;
  logic [CW-1:0] data_mask;
  logic [CW-1:0] cmp_din;
  logic [CW-1:0] cmp_data_mask;
  logic          busy;
  logic          match;
  logic [DP-1:0] match_addr;

  int n_chk;
  int n_pass;

  unencoded_tcam #(
    .CMP_WIDTH (CW),
    .DEPTH     (DP),
    .DEPTH_BITS(AB),
    .WR_LATENCY(LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .we           (we),
    .wr_addr      (wr_addr),
    .din          (din),
    .data_mask    (data_mask),
    .cmp_din      (cmp_din),
    .cmp_data_mask(cmp_data_mask),
    .busy         (busy),
    .match        (match),
    .match_addr   (match_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [31:0] k, input logic [31:0] km);
    cmp_din       = k;
    cmp_data_mask = km;
  endtask

  // Issue a write and let it run to completion (busy drops afterwards).
  task automatic write_full(input logic [3:0] a, input logic [31:0] d, input logic [31:0] m);
    we        = 1'b1;
    wr_addr   = a;
    din       = d;
    data_mask = m;
    step();
    we = 1'b0;
    repeat (LAT) step();
    chk("write_done_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_chk         = 0;
    n_pass        = 0;
    reset         = 1'b1;
    we            = 1'b0;
    wr_addr       = 4'd0;
    din           = 32'h0000_0000;
    data_mask     = 32'h0000_0000;
    cmp_din       = 32'h0000_0000;
    cmp_data_mask = 32'h0000_0000;
    repeat (3) step();
    reset = 1'b0;

    // Post-reset
    key(32'h0000_0000, 32'h0000_0000);
    step();
    chk("rst_match_addr", {16'd0, match_addr}, 32'h0000_0000);
    chk("rst_match", {31'd0, match}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Write/commit timing: write in cycle N, busy N+1..N+16, key at N+16 hits at N+17
    we        = 1'b1;
    wr_addr   = 4'd3;
    din       = 32'hC0A8_0001;
    data_mask = 32'h0000_0000;
    key(32'hC0A8_0001, 32'h0000_0000);
    step();
    we = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      chk($sformatf("busy_c%0d", i), {31'd0, busy}, 32'd1);
      if (i == LAT) chk("pre_commit_key", {16'd0, match_addr}, 32'h0000_0000);
      step();
    end
    chk("post_commit_busy", {31'd0, busy}, 32'd0);
    chk("commit_key_hit", {16'd0, match_addr}, 32'h0000_0008);
    chk("commit_match", {31'd0, match}, 32'd1);

    // Ternary multi-match
    write_full(4'd2, 32'h0A00_0000, 32'h00FF_FFFF);
    write_full(4'd5, 32'h0A01_0203, 32'h0000_0000);
    key(32'h0A01_0203, 32'h0000_0000);
    step();
    chk("multi_addr", {16'd0, match_addr}, 32'h0000_0024);
    chk("multi_match", {31'd0, match}, 32'd1);
    key(32'h0A01_0204, 32'h0000_0000);
    step();
    chk("mask_only_e2", {16'd0, match_addr}, 32'h0000_0004);

    // Lookup-side mask: all don't-care hits every valid entry (2, 3, 5)
    key(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    chk("lookup_mask_all", {16'd0, match_addr}, 32'h0000_002C);
    key(32'h0A01_02FF, 32'h0000_00FF);
    step();
    chk("lookup_mask_byte", {16'd0, match_addr}, 32'h0000_0024);

    // No match
    key(32'h1234_5678, 32'h0000_0000);
    step();
    chk("nomatch_addr", {16'd0, match_addr}, 32'h0000_0000);
    chk("nomatch_match", {31'd0, match}, 32'd0);

    // Rewrite entry 5 with a simultaneous compare, then an ignored write to 7
    we        = 1'b1;
    wr_addr   = 4'd5;
    din       = 32'h1111_1111;
    data_mask = 32'h0000_0000;
    key(32'h0A01_0203, 32'h0000_0000);
    step();
    chk("rewrite_same_cycle", {16'd0, match_addr}, 32'h0000_0024);
    wr_addr = 4'd7;
    din     = 32'h7777_7777;
    step();
    we = 1'b0;
    chk("rewrite_old_gone", {16'd0, match_addr}, 32'h0000_0004);
    repeat (LAT - 1) step();
    chk("ignored_we_busy", {31'd0, busy}, 32'd0);
    key(32'h7777_7777, 32'h0000_0000);
    step();
    chk("ignored_e7", {16'd0, match_addr}, 32'h0000_0000);
    key(32'h1111_1111, 32'h0000_0000);
    step();
    chk("rewrite_new_e5", {16'd0, match_addr}, 32'h0000_0020);
    key(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    chk("after_rewrite_all", {16'd0, match_addr}, 32'h0000_002C);

    // Reset four cycles into a write
    we        = 1'b1;
    wr_addr   = 4'd9;
    din       = 32'h9999_9999;
    data_mask = 32'h0000_0000;
    step();
    we = 1'b0;
    repeat (3) step();
    chk("midwrite_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_match", {16'd0, match_addr}, 32'h0000_0000);
    key(32'h9999_9999, 32'h0000_0000);
    for (int i = 0; i < LAT + 4; i++) begin
      step();
      if (match_addr !== 16'h0000 || busy !== 1'b0) begin
        chk("aborted_write_idle", {15'd0, busy, match_addr}, 32'h0000_0000);
      end
    end
    chk("aborted_e9", {16'd0, match_addr}, 32'h0000_0000);
    key(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    chk("all_invalid", {16'd0, match_addr}, 32'h0000_0000);
    chk("all_invalid_match", {31'd0, match}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
